axis_frame_arbiter: RTL



---
 rtl/axis_arb_pkg.sv | 17 +
 rtl/axis_rr_pick.sv | 31 +++
 rtl/axis_frame_arbiter.sv | 125 ++++++++++++
 3 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the frame-granular AXI4-Stream arbiter.
package axis_arb_pkg;

    // Controller state: IDLE searches for a requester, BUSY holds one frame.
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    // Width of a port index; a one-port build would otherwise get zero bits.
    function automatic int arb_id_width(input int ports);
        int w;
        w = $clog2(ports);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first requester after last_ptr wins.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int PORTS = 4,
    parameter int IW    = arb_id_width(PORTS)
) (
    input  logic [PORTS-1:0] req,
    input  logic [IW-1:0]    last_ptr,
    output logic [IW-1:0]    pick_idx,
    output logic             pick_v
);

    logic [PORTS-1:0] req_rot;
    int               start;

    // Rotate the doubled request vector so the search origin lands on bit 0,
    // then take the lowest set bit and map it back to an absolute index.
    always_comb begin
        start    = (int'(last_ptr) + 1) % PORTS;
        req_rot  = PORTS'({req, req} >> start);
        pick_v   = |req;
        pick_idx = '0;
        for (int i = PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_idx = IW'((start + i) % PORTS);
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-granular round-robin arbiter sharing one AXI4-Stream sink.
//
// Handshake: a beat moves on a port when its tvalid and tready are both high
// at a rising clock edge. Sources may raise or drop tvalid at will; the
// arbiter never derives any tready from a tvalid, only from the sink's
// m_axis_tready and the registered grant. A grant is held from the first
// beat until the beat carrying tlast is accepted, so frames never interleave.
module axis_frame_arbiter
    import axis_arb_pkg::*;
#(
    parameter int PORTS      = 4,
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1,
    parameter int ID_WIDTH   = $clog2(PORTS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [PORTS-1:0]           s_axis_tvalid,
    output logic [PORTS-1:0]           s_axis_tready,
    input  logic [PORTS-1:0]           s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]      m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]      m_axis_tkeep,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic                       m_axis_tlast,
    output logic [USER_WIDTH-1:0]      m_axis_tuser,
    output logic [ID_WIDTH-1:0]        m_axis_tid,
    output logic [PORTS-1:0]           grant,
    output logic                       busy
);

    localparam int IW = arb_id_width(PORTS);

    arb_state_e     state;
    logic [IW-1:0]  gnt_idx;
    logic [IW-1:0]  last_ptr;
    logic [IW-1:0]  pick_idx;
    logic           pick_v;
    logic [PORTS-1:0] pick_onehot;
    logic           frame_end;

    axis_rr_pick #(
        .PORTS (PORTS),
        .IW    (IW)
    ) u_pick (
        .req      (s_axis_tvalid),
        .last_ptr (last_ptr),
        .pick_idx (pick_idx),
        .pick_v   (pick_v)
    );

    // Decode the picked index into the one-hot grant pattern.
    always_comb begin
        pick_onehot = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (pick_idx == IW'(i)) begin
                pick_onehot[i] = 1'b1;
            end
        end
    end

    assign frame_end = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Arbitration FSM; busy mirrors the state register so it is visible outside.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ARB_IDLE;
            grant    <= '0;
            gnt_idx  <= '0;
            last_ptr <= IW'(PORTS - 1);
            busy     <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (enable && pick_v) begin
                        grant   <= pick_onehot;
                        gnt_idx <= pick_idx;
                        busy    <= 1'b1;
                        state   <= ARB_BUSY;
                    end
                end
                ARB_BUSY: begin
                    if (frame_end) begin
                        last_ptr <= gnt_idx;
                        grant    <= '0;
                        busy     <= 1'b0;
                        state    <= ARB_IDLE;
                    end
                end
                default: begin
                    grant <= '0;
                    busy  <= 1'b0;
                    state <= ARB_IDLE;
                end
            endcase
        end
    end

    // Output mux and ready steering; everything reads zero while idle.
    always_comb begin
        m_axis_tdata  = '0;
        m_axis_tkeep  = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tuser  = '0;
        s_axis_tready = '0;
        m_axis_tid    = busy ? ID_WIDTH'(gnt_idx) : '0;
        for (int i = 0; i < PORTS; i++) begin
            if (busy && (gnt_idx == IW'(i))) begin
                m_axis_tdata     = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                m_axis_tkeep     = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
                m_axis_tvalid    = s_axis_tvalid[i];
                m_axis_tlast     = s_axis_tlast[i];
                m_axis_tuser     = s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
                s_axis_tready[i] = m_axis_tready;
            end
        end
    end

endmodule
